// File: rtl/calc2_req_sched.sv
// calc2_req_sched: front-end scheduler for the calc2 engine.
//
// Each of the NPORT requester ports issues two-cycle commands. The first cycle
// carries cmd, tag and operand1. The second cycle carries operand2. A per-port
// capture FSM assembles each command. Valid commands go into a per-port queue
// of QDEPTH entries. A round-robin arbiter shares the single ALU issue channel
// between the queues. Invalid commands are answered locally with response 3.
// ALU results are steered back to the response bus of the originating port.
//
// Ports:
//   c_clk, reset            clock (rising edge), asynchronous active-low reset
//   req_cmd_in/data/tag     per-port command, operand and tag inputs
//   port_busy               per-port queue full (registered)
//   drop_err                per-port sticky "command dropped while busy"
//   alu_valid/ready         issue handshake; alu_cmd/op1/op2/tag/port payload
//   alu_rsp_*               one-cycle ALU result strobe with code/data/tag/port
//   out_resp/data/tag       per-port one-cycle response (0 none, 1 ok,
//                           2 overflow, 3 invalid)
module calc2_req_sched #(
    parameter int NPORT  = 4,
    parameter int DW     = 32,
    parameter int TW     = 2,
    parameter int QDEPTH = 2
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic [4*NPORT-1:0]  req_cmd_in,
    input  logic [DW*NPORT-1:0] req_data_in,
    input  logic [TW*NPORT-1:0] req_tag_in,
    output logic [NPORT-1:0]    port_busy,
    output logic [NPORT-1:0]    drop_err,
    output logic                alu_valid,
    input  logic                alu_ready,
    output logic [3:0]          alu_cmd,
    output logic [DW-1:0]       alu_op1,
    output logic [DW-1:0]       alu_op2,
    output logic [TW-1:0]       alu_tag,
    output logic [1:0]          alu_port,
    input  logic                alu_rsp_valid,
    input  logic [1:0]          alu_rsp,
    input  logic [DW-1:0]       alu_rsp_data,
    input  logic [TW-1:0]       alu_rsp_tag,
    input  logic [1:0]          alu_rsp_port,
    output logic [2*NPORT-1:0]  out_resp,
    output logic [DW*NPORT-1:0] out_data,
    output logic [TW*NPORT-1:0] out_tag
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    localparam logic [1:0] RESP_NONE    = 2'd0;
    localparam logic [1:0] RESP_INVALID = 2'd3;

    typedef enum logic { CAP_IDLE = 1'b0, CAP_OP2 = 1'b1 } cap_state_e;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [TW-1:0] tag;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } entry_t;

    // Commands the ALU understands: add, sub, shl, shr.
    function automatic logic is_valid_cmd(input logic [3:0] cmd);
        return (cmd == 4'd1) || (cmd == 4'd2) || (cmd == 4'd5) || (cmd == 4'd6);
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(QDEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    // Capture FSM state and the first-cycle fields of the command in flight.
    cap_state_e    cap_state_q [NPORT];
    cap_state_e    cap_state_d [NPORT];
    logic [3:0]    cap_cmd_q   [NPORT];
    logic [3:0]    cap_cmd_d   [NPORT];
    logic [TW-1:0] cap_tag_q   [NPORT];
    logic [TW-1:0] cap_tag_d   [NPORT];
    logic [DW-1:0] cap_op1_q   [NPORT];
    logic [DW-1:0] cap_op1_d   [NPORT];
    logic [NPORT-1:0] cap_drop_q, cap_drop_d;

    // Per-port queues.
    entry_t        q_mem_q [NPORT][QDEPTH];
    entry_t        q_mem_d [NPORT][QDEPTH];
    logic [AW-1:0] q_rd_q  [NPORT];
    logic [AW-1:0] q_rd_d  [NPORT];
    logic [AW-1:0] q_wr_q  [NPORT];
    logic [AW-1:0] q_wr_d  [NPORT];
    logic [CW-1:0] q_cnt_q [NPORT];
    logic [CW-1:0] q_cnt_d [NPORT];
    logic [NPORT-1:0] q_wr_en, q_pop, fresh_inv;

    logic [NPORT-1:0] busy_q, busy_d;
    logic [NPORT-1:0] drop_err_q, drop_err_d;

    // Pending-invalid responses waiting for a free response slot.
    logic [NPORT-1:0] pinv_q, pinv_d;
    logic [TW-1:0]    pinv_tag_q [NPORT];
    logic [TW-1:0]    pinv_tag_d [NPORT];
    logic [TW-1:0]    inv_tag;

    // Arbiter and registered issue payload.
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic       alu_valid_q, alu_valid_d;
    logic [1:0] alu_sel_q, alu_sel_d;
    entry_t     alu_ent_q, alu_ent_d;
    logic [1:0] arb_idx;

    // Registered per-port responses.
    logic [1:0]    out_resp_q [NPORT];
    logic [1:0]    out_resp_d [NPORT];
    logic [DW-1:0] out_data_q [NPORT];
    logic [DW-1:0] out_data_d [NPORT];
    logic [TW-1:0] out_tag_q  [NPORT];
    logic [TW-1:0] out_tag_d  [NPORT];

    // Capture FSMs, queue write/pop, busy and drop tracking.
    always_comb begin
        cap_state_d = cap_state_q;
        cap_cmd_d   = cap_cmd_q;
        cap_tag_d   = cap_tag_q;
        cap_op1_d   = cap_op1_q;
        cap_drop_d  = cap_drop_q;
        q_mem_d     = q_mem_q;
        q_rd_d      = q_rd_q;
        q_wr_d      = q_wr_q;
        q_cnt_d     = q_cnt_q;
        busy_d      = busy_q;
        drop_err_d  = drop_err_q;
        q_wr_en     = '0;
        q_pop       = '0;
        fresh_inv   = '0;
        for (int p = 0; p < NPORT; p++) begin
            q_pop[p] = alu_valid_q && alu_ready && (alu_sel_q == 2'(p));
            if (cap_state_q[p] == CAP_IDLE) begin
                if (req_cmd_in[4*p +: 4] != 4'd0) begin
                    cap_state_d[p] = CAP_OP2;
                    cap_cmd_d[p]   = req_cmd_in[4*p +: 4];
                    cap_tag_d[p]   = req_tag_in[TW*p +: TW];
                    cap_op1_d[p]   = req_data_in[DW*p +: DW];
                    // A dropped command still walks through OP2 so that its
                    // operand2 cycle is not mistaken for a new command.
                    cap_drop_d[p]  = busy_q[p];
                    if (busy_q[p]) begin
                        drop_err_d[p] = 1'b1;
                    end
                end
            end else begin
                cap_state_d[p] = CAP_IDLE;
                if (!cap_drop_q[p]) begin
                    if (is_valid_cmd(cap_cmd_q[p])) begin
                        q_wr_en[p] = 1'b1;
                    end else begin
                        fresh_inv[p] = 1'b1;
                    end
                end
            end
            if (q_wr_en[p]) begin
                q_mem_d[p][q_wr_q[p]].cmd = cap_cmd_q[p];
                q_mem_d[p][q_wr_q[p]].tag = cap_tag_q[p];
                q_mem_d[p][q_wr_q[p]].op1 = cap_op1_q[p];
                q_mem_d[p][q_wr_q[p]].op2 = req_data_in[DW*p +: DW];
                q_wr_d[p] = ptr_inc(q_wr_q[p]);
            end
            if (q_pop[p]) begin
                q_rd_d[p] = ptr_inc(q_rd_q[p]);
            end
            q_cnt_d[p] = q_cnt_q[p] + CW'(q_wr_en[p]) - CW'(q_pop[p]);
            busy_d[p]  = (q_cnt_d[p] == CW'(QDEPTH));
        end
    end

    // Round-robin arbiter. Selection is made from the post-update queue state
    // so a command written this cycle can be presented the next cycle. While
    // stalled (valid without ready) the selection and payload are frozen.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        alu_valid_d = alu_valid_q;
        alu_sel_d   = alu_sel_q;
        alu_ent_d   = alu_ent_q;
        arb_idx     = '0;
        if (alu_valid_q && alu_ready) begin
            rr_ptr_d = alu_sel_q;
        end
        if (!alu_valid_q || alu_ready) begin
            alu_valid_d = 1'b0;
            alu_sel_d   = '0;
            alu_ent_d   = '0;
            for (int k = 1; k <= NPORT; k++) begin
                arb_idx = rr_ptr_d + 2'(k);
                if (!alu_valid_d && (q_cnt_d[arb_idx] != '0)) begin
                    alu_valid_d = 1'b1;
                    alu_sel_d   = arb_idx;
                    alu_ent_d   = q_mem_d[arb_idx][q_rd_d[arb_idx]];
                end
            end
        end
    end

    // Response steering. An ALU result always takes the slot. A local invalid
    // response is held pending until a cycle where its port is free.
    always_comb begin
        pinv_d     = pinv_q;
        pinv_tag_d = pinv_tag_q;
        inv_tag    = '0;
        for (int p = 0; p < NPORT; p++) begin
            out_resp_d[p] = RESP_NONE;
            out_data_d[p] = '0;
            out_tag_d[p]  = '0;
            inv_tag = pinv_q[p] ? pinv_tag_q[p] : cap_tag_q[p];
            if (alu_rsp_valid && (alu_rsp_port == 2'(p))) begin
                out_resp_d[p] = alu_rsp;
                out_data_d[p] = alu_rsp_data;
                out_tag_d[p]  = alu_rsp_tag;
                pinv_d[p]     = pinv_q[p] | fresh_inv[p];
                pinv_tag_d[p] = inv_tag;
            end else if (pinv_q[p] || fresh_inv[p]) begin
                out_resp_d[p] = RESP_INVALID;
                out_tag_d[p]  = inv_tag;
                // If an older invalid is emitted now, a fresh one still waits.
                pinv_d[p]     = pinv_q[p] & fresh_inv[p];
                pinv_tag_d[p] = cap_tag_q[p];
            end
        end
    end

    // Control state and all outputs are reset.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NPORT; p++) begin
                cap_state_q[p] <= CAP_IDLE;
                q_rd_q[p]      <= '0;
                q_wr_q[p]      <= '0;
                q_cnt_q[p]     <= '0;
                pinv_tag_q[p]  <= '0;
                out_resp_q[p]  <= RESP_NONE;
                out_data_q[p]  <= '0;
                out_tag_q[p]   <= '0;
            end
            cap_drop_q  <= '0;
            busy_q      <= '0;
            drop_err_q  <= '0;
            pinv_q      <= '0;
            rr_ptr_q    <= 2'd3;
            alu_valid_q <= 1'b0;
            alu_sel_q   <= '0;
            alu_ent_q   <= '0;
        end else begin
            cap_state_q <= cap_state_d;
            q_rd_q      <= q_rd_d;
            q_wr_q      <= q_wr_d;
            q_cnt_q     <= q_cnt_d;
            pinv_tag_q  <= pinv_tag_d;
            out_resp_q  <= out_resp_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            cap_drop_q  <= cap_drop_d;
            busy_q      <= busy_d;
            drop_err_q  <= drop_err_d;
            pinv_q      <= pinv_d;
            rr_ptr_q    <= rr_ptr_d;
            alu_valid_q <= alu_valid_d;
            alu_sel_q   <= alu_sel_d;
            alu_ent_q   <= alu_ent_d;
        end
    end

    // Captured fields and queue storage are qualified by control state.
    always_ff @(posedge c_clk) begin
        cap_cmd_q <= cap_cmd_d;
        cap_tag_q <= cap_tag_d;
        cap_op1_q <= cap_op1_d;
        q_mem_q   <= q_mem_d;
    end

    assign port_busy = busy_q;
    assign drop_err  = drop_err_q;
    assign alu_valid = alu_valid_q;
    assign alu_port  = alu_sel_q;
    assign alu_cmd   = alu_ent_q.cmd;
    assign alu_op1   = alu_ent_q.op1;
    assign alu_op2   = alu_ent_q.op2;
    assign alu_tag   = alu_ent_q.tag;

    for (genvar g = 0; g < NPORT; g++) begin : g_out
        assign out_resp[2*g +: 2]   = out_resp_q[g];
        assign out_data[DW*g +: DW] = out_data_q[g];
        assign out_tag[TW*g +: TW]  = out_tag_q[g];
    end

endmodule

// File: tb/tb_calc2_req_sched.sv
// Scoreboard bench for calc2_req_sched: expected issues and responses are
// queued by the stimulus, a negedge monitor pops and compares them.
module tb_calc2_req_sched;
    localparam int NPORT = 4;
    localparam int DW    = 32;
    localparam int TW    = 2;

    logic                c_clk = 1'b0;
    logic                reset = 1'b1;
    logic [4*NPORT-1:0]  req_cmd_in;
    logic [DW*NPORT-1:0] req_data_in;
    logic [TW*NPORT-1:0] req_tag_in;
    logic [NPORT-1:0]    port_busy, drop_err;
    logic                alu_valid, alu_ready;
    logic [3:0]          alu_cmd;
    logic [DW-1:0]       alu_op1, alu_op2;
    logic [TW-1:0]       alu_tag;
    logic [1:0]          alu_port;
    logic                alu_rsp_valid;
    logic [1:0]          alu_rsp;
    logic [DW-1:0]       alu_rsp_data;
    logic [TW-1:0]       alu_rsp_tag;
    logic [1:0]          alu_rsp_port;
    logic [2*NPORT-1:0]  out_resp;
    logic [DW*NPORT-1:0] out_data;
    logic [TW*NPORT-1:0] out_tag;

    calc2_req_sched #(.NPORT(NPORT), .DW(DW), .TW(TW), .QDEPTH(2)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .port_busy(port_busy), .drop_err(drop_err),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_cmd(alu_cmd),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_tag(alu_tag), .alu_port(alu_port),
        .alu_rsp_valid(alu_rsp_valid), .alu_rsp(alu_rsp), .alu_rsp_data(alu_rsp_data),
        .alu_rsp_tag(alu_rsp_tag), .alu_rsp_port(alu_rsp_port),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [1:0]    port;
        logic [3:0]    cmd;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [TW-1:0] tag;
    } iss_t;

    typedef struct {
        logic [1:0]    port;
        logic [1:0]    resp;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } rsp_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    iss_t mon_iss;
    rsp_t mon_rsp;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_iss(input int p, input logic [3:0] cmd, input logic [DW-1:0] op1,
                            input logic [DW-1:0] op2, input logic [TW-1:0] tag);
        iss_t e;
        e.port = 2'(p); e.cmd = cmd; e.op1 = op1; e.op2 = op2; e.tag = tag;
        exp_iss.push_back(e);
    endtask

    task automatic push_rsp(input int p, input logic [1:0] resp, input logic [DW-1:0] data,
                            input logic [TW-1:0] tag);
        rsp_t e;
        e.port = 2'(p); e.resp = resp; e.data = data; e.tag = tag;
        exp_rsp.push_back(e);
    endtask

    // Monitor: every issue handshake and every nonzero response is matched
    // against the front of its expectation queue.
    always @(negedge c_clk) begin
        if (alu_valid && alu_ready) begin
            if (exp_iss.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_issue: port %0d cmd %0d op1 %0h, none expected",
                         alu_port, alu_cmd, alu_op1);
            end else begin
                mon_iss = exp_iss.pop_front();
                check("issue", {alu_port, alu_cmd, alu_op1, alu_op2, alu_tag},
                      {mon_iss.port, mon_iss.cmd, mon_iss.op1, mon_iss.op2, mon_iss.tag});
            end
        end
        for (int p = 0; p < NPORT; p++) begin
            if (out_resp[2*p +: 2] != 2'd0) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: port %0d resp %0d, none expected",
                             p, out_resp[2*p +: 2]);
                end else begin
                    mon_rsp = exp_rsp.pop_front();
                    check("response", {2'(p), out_resp[2*p +: 2], out_data[DW*p +: DW], out_tag[TW*p +: TW]},
                          {mon_rsp.port, mon_rsp.resp, mon_rsp.data, mon_rsp.tag});
                end
            end
        end
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int p, input logic [3:0] cmd, input logic [DW-1:0] op1,
                        input logic [DW-1:0] op2, input logic [TW-1:0] tag);
        req_cmd_in[4*p +: 4]    = cmd;
        req_data_in[DW*p +: DW] = op1;
        req_tag_in[TW*p +: TW]  = tag;
        tick();
        req_cmd_in[4*p +: 4]    = 4'd0;
        req_data_in[DW*p +: DW] = op2;
        req_tag_in[TW*p +: TW]  = '0;
        tick();
        req_data_in[DW*p +: DW] = '0;
    endtask

    // Same command on every port in mask; operands 0x10+p / 0x20+p, tag p.
    task automatic send_mask(input logic [NPORT-1:0] mask, input logic [3:0] cmd);
        for (int p = 0; p < NPORT; p++) begin
            if (mask[p]) begin
                req_cmd_in[4*p +: 4]    = cmd;
                req_data_in[DW*p +: DW] = DW'(32'h10 + p);
                req_tag_in[TW*p +: TW]  = TW'(p);
            end
        end
        tick();
        for (int p = 0; p < NPORT; p++) begin
            if (mask[p]) begin
                req_cmd_in[4*p +: 4]    = 4'd0;
                req_data_in[DW*p +: DW] = DW'(32'h20 + p);
                req_tag_in[TW*p +: TW]  = '0;
            end
        end
        tick();
        req_data_in = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
        alu_ready = 1'b1; alu_rsp_valid = 1'b0; alu_rsp = '0;
        alu_rsp_data = '0; alu_rsp_tag = '0; alu_rsp_port = '0;
        #1 reset = 1'b0;
        ticks(2);

        // Reset state.
        check("rst_alu_valid", alu_valid, 1'b0);
        check("rst_port_busy", port_busy, 4'h0);
        check("rst_drop_err", drop_err, 4'h0);
        check("rst_out_resp", out_resp, 8'h0);
        check("rst_out_data", out_data, 128'h0);
        check("rst_out_tag", out_tag, 8'h0);
        check("rst_payload", {alu_port, alu_cmd, alu_op1, alu_op2, alu_tag}, 72'h0);
        reset = 1'b1;
        tick();

        // Single add on port 1, then its ALU result comes back.
        push_iss(1, 4'd1, 32'h5, 32'h7, 2'd2);
        send(1, 4'd1, 32'h5, 32'h7, 2'd2);
        check("t1_latency_valid", alu_valid, 1'b1);
        check("t1_latency_port", alu_port, 2'd1);
        push_rsp(1, 2'd1, 32'hC, 2'd2);
        alu_rsp_valid = 1'b1; alu_rsp = 2'd1; alu_rsp_data = 32'hC;
        alu_rsp_tag = 2'd2; alu_rsp_port = 2'd1;
        tick();
        alu_rsp_valid = 1'b0; alu_rsp = '0; alu_rsp_data = '0; alu_rsp_tag = '0; alu_rsp_port = '0;
        check("t1_valid_drops", alu_valid, 1'b0);
        check("t1_resp_port1", out_resp[3:2], 2'd1);
        tick();
        check("t1_resp_one_cycle", out_resp[3:2], 2'd0);

        // Four simultaneous commands after reset: order 0,1,2,3; then 0,2.
        pulse_reset();
        for (int p = 0; p < NPORT; p++) push_iss(p, 4'd1, DW'(32'h10 + p), DW'(32'h20 + p), TW'(p));
        send_mask(4'hF, 4'd1);
        check("t2_first_port", alu_port, 2'd0);
        ticks(6);
        push_iss(0, 4'd1, 32'h10, 32'h20, 2'd0);
        push_iss(2, 4'd1, 32'h12, 32'h22, 2'd2);
        send_mask(4'h5, 4'd1);
        ticks(4);

        // Invalid command on port 3, answered locally two cycles later.
        push_rsp(3, 2'd3, 32'h0, 2'd1);
        send(3, 4'd4, 32'hAA, 32'hBB, 2'd1);
        check("t3_invalid_resp", out_resp[7:6], 2'd3);
        check("t3_invalid_tag", out_tag[7:6], 2'd1);
        check("t3_no_issue", alu_valid, 1'b0);
        tick();

        // Invalid collides with an ALU result for port 3: ALU first.
        push_rsp(3, 2'd2, 32'hDEAD, 2'd0);
        push_rsp(3, 2'd3, 32'h0, 2'd1);
        req_cmd_in[15:12] = 4'd7; req_tag_in[7:6] = 2'd1;
        tick();
        req_cmd_in[15:12] = 4'd0; req_tag_in[7:6] = 2'd0;
        alu_rsp_valid = 1'b1; alu_rsp = 2'd2; alu_rsp_data = 32'hDEAD;
        alu_rsp_tag = 2'd0; alu_rsp_port = 2'd3;
        tick();
        alu_rsp_valid = 1'b0; alu_rsp = '0; alu_rsp_data = '0; alu_rsp_tag = '0; alu_rsp_port = '0;
        check("t3_collide_alu_first", out_resp[7:6], 2'd2);
        tick();
        check("t3_collide_invalid_next", out_resp[7:6], 2'd3);
        tick();

        // Stall for five cycles with ports 0 and 2 pending.
        alu_ready = 1'b0;
        push_iss(0, 4'd1, 32'h10, 32'h20, 2'd0);
        push_iss(2, 4'd1, 32'h12, 32'h22, 2'd2);
        send_mask(4'h5, 4'd1);
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_hold", {alu_valid, alu_port, alu_cmd, alu_op1, alu_op2, alu_tag},
                  {1'b1, 2'd0, 4'd1, 32'h10, 32'h20, 2'd0});
            tick();
        end
        alu_ready = 1'b1;
        ticks(4);

        // Three back-to-back commands on port 2 while stalled: third dropped.
        alu_ready = 1'b0;
        push_iss(2, 4'd1, 32'h100, 32'h200, 2'd1);
        push_iss(2, 4'd2, 32'h300, 32'h400, 2'd2);
        send(2, 4'd1, 32'h100, 32'h200, 2'd1);
        check("t5_not_busy_after_first", port_busy[2], 1'b0);
        send(2, 4'd2, 32'h300, 32'h400, 2'd2);
        check("t5_busy_after_second", port_busy[2], 1'b1);
        send(2, 4'd5, 32'h500, 32'h600, 2'd3);
        check("t5_drop_err", drop_err, 4'b0100);
        check("t5_still_busy", port_busy[2], 1'b1);
        alu_ready = 1'b1;
        ticks(5);
        check("t5_busy_cleared", port_busy[2], 1'b0);
        check("t5_drop_sticky", drop_err[2], 1'b1);

        // Reset during port 0 OP2 with port 1 queued.
        alu_ready = 1'b0;
        send(1, 4'd2, 32'h11, 32'h22, 2'd3);
        check("t6_queued_valid", {alu_valid, alu_port}, {1'b1, 2'd1});
        req_cmd_in[3:0] = 4'd1; req_data_in[31:0] = 32'h55; req_tag_in[1:0] = 2'd1;
        tick();
        req_cmd_in[3:0] = 4'd0; req_data_in[31:0] = 32'h66; req_tag_in[1:0] = 2'd0;
        #2 reset = 1'b0;
        #1;
        check("t6_async_valid", alu_valid, 1'b0);
        check("t6_async_payload", {alu_port, alu_cmd, alu_op1, alu_op2, alu_tag}, 72'h0);
        check("t6_async_drop_err", drop_err, 4'h0);
        check("t6_async_busy", port_busy, 4'h0);
        tick();
        req_data_in = '0;
        reset = 1'b1;
        alu_ready = 1'b1;
        ticks(4);
        check("t6_no_issue_after_reset", alu_valid, 1'b0);
        push_iss(0, 4'd1, 32'h10, 32'h20, 2'd0);
        push_iss(3, 4'd1, 32'h13, 32'h23, 2'd3);
        send_mask(4'h9, 4'd1);
        check("t6_ptr_restart", alu_port, 2'd0);
        ticks(5);

        check("end_issue_queue_empty", 128'(exp_iss.size()), 128'd0);
        check("end_resp_queue_empty", 128'(exp_rsp.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc2_req_sched.md
Name: calc2_req_sched

Overview:
- Front-end scheduler for the calc2 engine.
- Captures two-cycle commands from four requester ports into per-port 2-entry queues and shares one ALU issue channel between them using round-robin arbitration.
- Steers ALU results back to the originating port's response bus.
- Answers invalid commands locally, without using the ALU.

Parameters:
- NPORT, 4, number of requester ports (fixed at 4 for calc2).
- DW, 32, operand/result width.
- TW, 2, tag width.
- QDEPTH, 2, entries per port queue.

Ports:
- c_clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_cmd_in  in  4*NPORT  per-port command; slice p = [4p+3:4p]; 0 = no command.
- req_data_in  in  DW*NPORT  per-port data: operand1 in the cmd cycle, operand2 in the next cycle.
- req_tag_in  in  TW*NPORT  per-port tag, valid in the cmd cycle.
- port_busy  out  NPORT  queue p full; requester must not start a command.
- drop_err  out  NPORT  sticky flag: command arrived while busy and was dropped.
- alu_valid  out  1  issue request.
- alu_ready  in  1  ALU accepts the issue.
- alu_cmd  out  4  issued command.
- alu_op1  out  DW  issued operand1.
- alu_op2  out  DW  issued operand2.
- alu_tag  out  TW  issued tag.
- alu_port  out  2  originating port of the issue.
- alu_rsp_valid  in  1  result strobe, one cycle.
- alu_rsp  in  2  result code: 1 ok, 2 overflow/underflow.
- alu_rsp_data  in  DW  result data.
- alu_rsp_tag  in  TW  result tag.
- alu_rsp_port  in  2  result port.
- out_resp  out  2*NPORT  per-port response; 0 = none, 1 ok, 2 overflow, 3 invalid.
- out_data  out  DW*NPORT  per-port result data.
- out_tag  out  TW*NPORT  per-port result tag.

Behaviour:
- Reset (reset = 0, async):
  - All outputs 0.
  - Queues empty; capture FSMs IDLE.
  - Round-robin pointer = 3, so port 0 has first priority.
  - Pending-invalid registers cleared.
  - drop_err cleared.
  - A command half-captured when reset asserts is discarded.
- Capture FSM per port:
  - IDLE: cmd != 0 in cycle t → latch cmd, tag, operand1; go to OP2.
  - OP2 (cycle t+1): latch operand2; go to IDLE.
    - Valid cmd (1 add, 2 sub, 5 shl, 6 shr): write the entry to the queue at the end of t+1.
    - Any other nonzero cmd: set pending-invalid for that port with the tag; no queue write.
  - Cmd inputs are ignored while in OP2.
- Busy and drop:
  - port_busy[p] = queue count == QDEPTH. It is registered and reflects the count after the current cycle's write/issue.
  - Cmd != 0 in IDLE while busy: command dropped; drop_err[p] <= 1 (cleared only by reset).
  - Its operand2 cycle is ignored.
- Arbiter:
  - alu_valid = 1 whenever any queue is non-empty.
  - Selected port = first non-empty queue searching from pointer+1 modulo 4.
  - Payload is registered. Once alu_valid rises, the selection and payload are held stable until alu_ready = 1; no re-arbitration while stalled.
  - On the alu_valid & alu_ready handshake: pop the selected queue; pointer <= selected port; next selection is computed for the following cycle.
  - Throughput: one issue per cycle with sustained alu_ready.
  - Minimum latency: op2 cycle t+1 → alu_valid at t+2.
  - Simultaneous write and pop on the same queue in the same cycle are both honoured; count unchanged.
- Response steering:
  - alu_rsp_valid in cycle r → out_resp/out_data/out_tag[alu_rsp_port] driven in cycle r+1 for exactly one cycle, then returned to 0.
  - Pending-invalid drives out_resp = 3, out_tag = latched tag, out_data = 0 for one cycle at t+2.
  - If an ALU response targets the same port in the same cycle, the ALU response wins and the invalid response waits for the next free cycle.
  - Only one pending-invalid can exist per port, because the next one needs at least two more cycles.
- Data widths: pass-through only; no arithmetic inside this block.

Test Plan:
- Port 1: cmd 1, op1 0x5, op2 0x7, tag 2, alu_ready = 1 → alu_valid two cycles after the cmd cycle with alu_port = 1, op1 = 5, op2 = 7. ALU returns rsp 1, data 0xC → out_resp[1] = 1, out_data = 0xC, out_tag = 2, for one cycle.
- All four ports issue cmd 1 in the same cycle after reset → issue order 0, 1, 2, 3. A repeat burst from ports 0 and 2 only → order 0, 2.
- Port 3: cmd 4, tag 1 → no ALU issue; out_resp[3] = 3, out_tag = 1 two cycles after the cmd cycle. Colliding with an ALU result for port 3 → ALU result first, invalid response the following cycle.
- alu_ready = 0 for 5 cycles with port 0 and port 2 pending → alu_port and payload stable throughout; port 0 issues on the first cycle ready = 1.
- Port 2 sends three commands back-to-back with alu_ready = 0 → port_busy[2] = 1 after the second. The third is dropped and drop_err[2] = 1. After ready rises, exactly two issues occur.
- reset pulsed low mid-OP2 on port 0, with queued entries present → all outputs 0 immediately; no issue after release; the pointer restarts at port 0.
